buffer_pixeles_mem_externa: RTL and testbench
=============================================

BUFFER_PIXELES_MEM_EXTERNA -- requirements
Module: buffer_pixeles_mem_externa

Interface
REQ-001 SHALL have parameter BITS_PALABRA, default 32, memory word width.
REQ-002 SHALL have parameter BITS_PIXEL, default 8, pixel width; BITS_PALABRA/BITS_PIXEL = pixels per word (default 4).
REQ-003 SHALL have parameter PROFUNDIDAD, default 8, word FIFO depth, power of two, at least 2.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 limpiar  input  1  synchronous clear, pulsed by the controller at image start.
REQ-008 save_mem_data  input  1  write strobe from the external-memory read controller.
REQ-009 mem_data  input  BITS_PALABRA  word read from external memory, valid while save_mem_data is high.
REQ-010 pixel_ready  input  1  downstream filter stage accepts a pixel.
REQ-011 pixel_out  output  BITS_PIXEL  current pixel.
REQ-012 pixel_valid  output  1  pixel_out is valid.
REQ-013 buf_space_available  output  1  at least one free FIFO word entry.
REQ-014 ocupacion  output  log2(PROFUNDIDAD)+1  number of words stored in the FIFO, excluding the output stage.
REQ-015 error_desborde  output  1  sticky flag: a write occurred while the FIFO was full.

Function
REQ-016 SHALL hold words in a circular FIFO with write and read pointers of log2(PROFUNDIDAD) bits, wrapping modulo PROFUNDIDAD.
REQ-017 SHALL write mem_data on an edge where save_mem_data=1 and ocupacion<PROFUNDIDAD.
REQ-018 SHALL discard the word and set error_desborde=1 on an edge where save_mem_data=1 and ocupacion=PROFUNDIDAD with no simultaneous pop.
REQ-019 SHALL accept the write on an edge where the FIFO is full and a pop occurs at the same edge; ocupacion stays at PROFUNDIDAD and error_desborde is not set.
REQ-020 SHALL drive buf_space_available = (ocupacion < PROFUNDIDAD), decoded combinationally from the registered count.
REQ-021 SHALL implement an output-stage FSM with two states: E_VACIO and E_ENTREGANDO.
REQ-022 Output stage contents: a word register and a pixel index of log2(BITS_PALABRA/BITS_PIXEL) bits.
REQ-023 E_VACIO: if ocupacion>0, pop one word into the word register, set index=0 and go to E_ENTREGANDO; otherwise stay.
REQ-024 E_ENTREGANDO: pixel_valid=1 and pixel_out = word bits [index*BITS_PIXEL +: BITS_PIXEL], giving little-endian order (bits 7:0 first).
REQ-025 SHALL transfer a pixel only on an edge where pixel_valid=1 and pixel_ready=1; on a transfer, index increments.
REQ-026 While pixel_ready=0, pixel_out SHALL hold stable.
REQ-027 On transfer of the last pixel of a word with ocupacion>0, SHALL pop the next word at the same edge, set index=0 and stay in E_ENTREGANDO, with no bubble.
REQ-028 On transfer of the last pixel of a word with ocupacion=0, SHALL go to E_VACIO; pixel_valid=0 in E_VACIO.
REQ-029 Latency: a word written at edge T into an empty FIFO with the output stage in E_VACIO SHALL be loaded at edge T+1, with pixel_valid=1 after T+1. There is no write-through bypass.
REQ-030 ocupacion SHALL update as +1 on a write only, -1 on a pop only, and unchanged on a simultaneous write and pop.
REQ-031 limpiar=1 SHALL, at the edge, zero both pointers, ocupacion, the index and error_desborde, force E_VACIO, and ignore any simultaneous save_mem_data; limpiar has priority over all other events.

Reset
REQ-032 reset=1 SHALL asynchronously force: E_VACIO, both pointers=0, ocupacion=0, index=0, word register=0, pixel_out=0, pixel_valid=0, error_desborde=0, buf_space_available=1.
REQ-033 FIFO storage array contents SHALL not require reset.
REQ-034 Reset asserted mid-transfer SHALL abandon the partially delivered word; after release the block behaves as empty.

Verification
REQ-035 Single word: write 0xDDCCBBAA at edge T with pixel_ready=1 -> pixel_valid from T+1, pixels 0xAA, 0xBB, 0xCC, 0xDD on 4 consecutive edges, then pixel_valid=0.
REQ-036 Back-to-back words: write 0x03020100 then 0x07060504, pixel_ready=1 -> 8 pixels 0x00..0x07 with no pixel_valid gap.
REQ-037 Fill: pixel_ready=0, write 9 words (output stage takes 1) -> after 9 writes ocupacion=8, buf_space_available=0; a 10th write -> error_desborde=1, that word is never output.
REQ-038 Full with simultaneous pop: FIFO full, last pixel of the current word accepted at the same edge as a write -> ocupacion stays 8, error_desborde=0, written word delivered in order.
REQ-039 Backpressure: toggle pixel_ready randomly over 16 words -> output equals the input byte stream in order; pixel_out is stable whenever pixel_valid=1 and pixel_ready=0.
REQ-040 Clear/reset: assert limpiar, and separately reset, during the delivery of pixel 2 -> next edge or immediately: pixel_valid=0, ocupacion=0, error_desborde=0, buf_space_available=1.

Source files
------------

// File: rtl/buffer_pixeles_mem_externa.sv
// Word FIFO fed by the external-memory read controller, followed by an output
// stage that serialises each word into pixels (least significant pixel first).
module buffer_pixeles_mem_externa #(
  parameter int unsigned BITS_PALABRA = 32,
  parameter int unsigned BITS_PIXEL   = 8,
  parameter int unsigned PROFUNDIDAD  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           limpiar,
  input  logic                           save_mem_data,
  input  logic [BITS_PALABRA-1:0]        mem_data,
  input  logic                           pixel_ready,
  output logic [BITS_PIXEL-1:0]          pixel_out,
  output logic                           pixel_valid,
  output logic                           buf_space_available,
  output logic [$clog2(PROFUNDIDAD):0]   ocupacion,
  output logic                           error_desborde
);

  localparam int unsigned PIXELES = BITS_PALABRA / BITS_PIXEL;
  localparam int unsigned AW      = $clog2(PROFUNDIDAD);
  localparam int unsigned CW      = AW + 1;
  localparam int unsigned IW      = (PIXELES > 1) ? $clog2(PIXELES) : 1;

  typedef enum logic {
    E_VACIO      = 1'b0,
    E_ENTREGANDO = 1'b1
  } estado_t;

  estado_t                 r_estado;
  estado_t                 w_estado_sig;

  logic [BITS_PALABRA-1:0] r_mem [PROFUNDIDAD];
  logic [AW-1:0]           r_ptr_wr;
  logic [AW-1:0]           r_ptr_rd;
  logic [CW-1:0]           r_ocup;
  logic [BITS_PALABRA-1:0] r_palabra;
  logic [IW-1:0]           r_indice;
  logic                    r_error;

  logic                    w_hay_datos;
  logic                    w_lleno;
  logic                    w_transfer;
  logic                    w_ultimo;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_desborde;

  assign w_hay_datos = (r_ocup != '0);
  assign w_lleno     = (r_ocup == CW'(PROFUNDIDAD));
  assign w_transfer  = (r_estado == E_ENTREGANDO) && pixel_ready;
  assign w_ultimo    = (r_indice == IW'(PIXELES - 1));

  // A write into a full FIFO is only legal when the output stage pops at the same edge
  assign w_push     = save_mem_data && !limpiar && (!w_lleno || w_pop);
  assign w_desborde = save_mem_data && !limpiar && w_lleno && !w_pop;

  // Output-stage state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado <= E_VACIO;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  // Next state and pop decision; a clear overrides everything
  always_comb begin
    w_estado_sig = r_estado;
    w_pop        = 1'b0;
    case (r_estado)
      E_VACIO: begin
        if (w_hay_datos) begin
          w_pop        = 1'b1;
          w_estado_sig = E_ENTREGANDO;
        end
      end
      E_ENTREGANDO: begin
        if (w_transfer && w_ultimo) begin
          if (w_hay_datos) begin
            w_pop = 1'b1;
          end else begin
            w_estado_sig = E_VACIO;
          end
        end
      end
      default: w_estado_sig = E_VACIO;
    endcase
    if (limpiar) begin
      w_pop        = 1'b0;
      w_estado_sig = E_VACIO;
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_ptr_wr] <= mem_data;
    end
  end

  // Pointers, occupancy, word register, pixel index and sticky overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr_wr  <= '0;
      r_ptr_rd  <= '0;
      r_ocup    <= '0;
      r_palabra <= '0;
      r_indice  <= '0;
      r_error   <= 1'b0;
    end else if (limpiar) begin
      r_ptr_wr  <= '0;
      r_ptr_rd  <= '0;
      r_ocup    <= '0;
      r_indice  <= '0;
      r_error   <= 1'b0;
    end else begin
      if (w_push) begin
        r_ptr_wr <= r_ptr_wr + AW'(1);
      end
      if (w_pop) begin
        r_ptr_rd  <= r_ptr_rd + AW'(1);
        r_palabra <= r_mem[r_ptr_rd];
        r_indice  <= '0;
      end else if (w_transfer) begin
        r_indice <= w_ultimo ? '0 : r_indice + IW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_ocup <= r_ocup + CW'(1);
        2'b01:   r_ocup <= r_ocup - CW'(1);
        default: r_ocup <= r_ocup;
      endcase
      if (w_desborde) begin
        r_error <= 1'b1;
      end
    end
  end

  assign pixel_out           = r_palabra[int'(r_indice) * BITS_PIXEL +: BITS_PIXEL];
  assign pixel_valid         = (r_estado == E_ENTREGANDO);
  assign buf_space_available = !w_lleno;
  assign ocupacion           = r_ocup;
  assign error_desborde      = r_error;

endmodule

// File: tb/tb_buffer_pixeles_mem_externa.sv
// Directed bench for the pixel buffer; a byte scoreboard is filled on each
// accepted write and drained by a monitor on every pixel transfer.
module tb_buffer_pixeles_mem_externa;

  logic        clk;
  logic        reset;
  logic        limpiar;
  logic        save_mem_data;
  logic [31:0] mem_data;
  logic        pixel_ready;
  logic [7:0]  pixel_out;
  logic        pixel_valid;
  logic        buf_space_available;
  logic [3:0]  ocupacion;
  logic        error_desborde;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sb[$];

  logic       hold_valid = 1'b0;
  logic [7:0] hold_pix   = '0;

  buffer_pixeles_mem_externa dut (
    .clk                 (clk),
    .reset               (reset),
    .limpiar             (limpiar),
    .save_mem_data       (save_mem_data),
    .mem_data            (mem_data),
    .pixel_ready         (pixel_ready),
    .pixel_out           (pixel_out),
    .pixel_valid         (pixel_valid),
    .buf_space_available (buf_space_available),
    .ocupacion           (ocupacion),
    .error_desborde      (error_desborde)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] w, input bit acc);
    save_mem_data = 1'b1;
    mem_data      = w;
    if (acc) begin
      for (int b = 0; b < 4; b++) sb.push_back(w[b*8 +: 8]);
    end
    step();
    save_mem_data = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    pixel_ready = 1'b1;
    while ((sb.size() != 0 || pixel_valid) && n < 300) begin
      step();
      n++;
    end
    chk(tag, 32'(n < 300), 32'd1);
  endtask

  // Monitor: compare transferred pixels in order, and check stability under backpressure
  always @(negedge clk) begin
    if (pixel_valid) begin
      if (hold_valid) chk("pixel_stable", 32'(pixel_out), 32'(hold_pix));
      if (pixel_ready) begin
        chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk("pixel", 32'(pixel_out), 32'(sb.pop_front()));
        hold_valid = 1'b0;
      end else begin
        hold_valid = 1'b1;
        hold_pix   = pixel_out;
      end
    end else begin
      hold_valid = 1'b0;
    end
  end

  initial begin
    int gaps;
    int written;
    int cyc;
    logic [31:0] w;

    reset         = 1'b1;
    limpiar       = 1'b0;
    save_mem_data = 1'b0;
    mem_data      = '0;
    pixel_ready   = 1'b0;
    #12;
    chk("rst_valid", 32'(pixel_valid), 32'd0);
    chk("rst_ocup", 32'(ocupacion), 32'd0);
    chk("rst_space", 32'(buf_space_available), 32'd1);
    chk("rst_err", 32'(error_desborde), 32'd0);
    chk("rst_pixel", 32'(pixel_out), 32'd0);
    step();
    reset = 1'b0;
    step();

    // Single word: latency of one edge, then four pixels
    pixel_ready = 1'b1;
    write_word(32'hDDCCBBAA, 1'b1);
    chk("single_valid_T", 32'(pixel_valid), 32'd0);
    chk("single_ocup_T", 32'(ocupacion), 32'd1);
    step();
    chk("single_valid_T1", 32'(pixel_valid), 32'd1);
    chk("single_pix0", 32'(pixel_out), 32'hAA);
    chk("single_ocup_T1", 32'(ocupacion), 32'd0);
    step(); step(); step();
    chk("single_pix3", 32'(pixel_out), 32'hDD);
    step();
    chk("single_valid_end", 32'(pixel_valid), 32'd0);

    // Back-to-back words, no bubble between them
    write_word(32'h03020100, 1'b1);
    write_word(32'h07060504, 1'b1);
    gaps = 0;
    for (int i = 0; i < 8; i++) begin
      if (!pixel_valid) gaps++;
      step();
    end
    chk("b2b_gaps", 32'(gaps), 32'd0);
    chk("b2b_valid_end", 32'(pixel_valid), 32'd0);

    // Fill with backpressure, then overflow
    pixel_ready = 1'b0;
    for (int i = 0; i < 9; i++) write_word(32'h10101010 * 32'(i + 1) + 32'h00010203, 1'b1);
    chk("fill_ocup", 32'(ocupacion), 32'd8);
    chk("fill_space", 32'(buf_space_available), 32'd0);
    chk("fill_err_before", 32'(error_desborde), 32'd0);
    write_word(32'hBADBADBA, 1'b0);
    chk("ovf_err", 32'(error_desborde), 32'd1);
    chk("ovf_ocup", 32'(ocupacion), 32'd8);
    drain("fill_drain");
    chk("ovf_err_sticky", 32'(error_desborde), 32'd1);
    limpiar = 1'b1;
    step();
    limpiar = 1'b0;
    chk("clr_err", 32'(error_desborde), 32'd0);

    // Full FIFO, last pixel accepted at the same edge as a write
    pixel_ready = 1'b0;
    for (int i = 0; i < 9; i++) write_word(32'h0F0E0D0C + 32'(i) * 32'h04040404, 1'b1);
    chk("full2_ocup", 32'(ocupacion), 32'd8);
    pixel_ready = 1'b1;
    step(); step(); step();
    write_word(32'hC0FFEE11, 1'b1);
    chk("fullpop_ocup", 32'(ocupacion), 32'd8);
    chk("fullpop_err", 32'(error_desborde), 32'd0);
    drain("fullpop_drain");

    // Random backpressure over 16 words
    written = 0;
    cyc     = 0;
    while ((written < 16 || sb.size() != 0 || pixel_valid) && cyc < 3000) begin
      pixel_ready = 1'($urandom_range(0, 1));
      if (written < 16 && buf_space_available && $urandom_range(0, 1) == 1) begin
        w = $urandom;
        save_mem_data = 1'b1;
        mem_data      = w;
        for (int b = 0; b < 4; b++) sb.push_back(w[b*8 +: 8]);
        written++;
      end else begin
        save_mem_data = 1'b0;
      end
      step();
      cyc++;
    end
    save_mem_data = 1'b0;
    chk("bp_done", 32'(cyc < 3000), 32'd1);

    // Clear during delivery of the second pixel, with a write that must be ignored
    pixel_ready = 1'b1;
    write_word(32'h44332211, 1'b1);
    write_word(32'h88776655, 1'b1);
    step();
    chk("clr_mid_pix", 32'(pixel_out), 32'h22);
    limpiar       = 1'b1;
    save_mem_data = 1'b1;
    mem_data      = 32'hDEADBEEF;
    step();
    limpiar       = 1'b0;
    save_mem_data = 1'b0;
    sb.delete();
    chk("clr_valid", 32'(pixel_valid), 32'd0);
    chk("clr_ocup", 32'(ocupacion), 32'd0);
    chk("clr_err2", 32'(error_desborde), 32'd0);
    chk("clr_space", 32'(buf_space_available), 32'd1);
    step(); step();
    chk("clr_valid_later", 32'(pixel_valid), 32'd0);
    chk("clr_ocup_later", 32'(ocupacion), 32'd0);

    // Asynchronous reset during delivery of the second pixel
    write_word(32'hA4A3A2A1, 1'b1);
    write_word(32'hB4B3B2B1, 1'b1);
    step();
    chk("rst_mid_pix", 32'(pixel_out), 32'hA2);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(pixel_valid), 32'd0);
    chk("arst_ocup", 32'(ocupacion), 32'd0);
    chk("arst_space", 32'(buf_space_available), 32'd1);
    chk("arst_err", 32'(error_desborde), 32'd0);
    chk("arst_pixel", 32'(pixel_out), 32'd0);
    sb.delete();
    step();
    reset = 1'b0;
    step(); step();
    chk("arst_valid_after", 32'(pixel_valid), 32'd0);
    chk("arst_ocup_after", 32'(ocupacion), 32'd0);

    // Normal operation resumes after reset
    write_word(32'h5A4B3C2D, 1'b1);
    drain("post_rst_drain");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
